// File: rtl/mips_lite_multicycle.sv
// mips_lite_multicycle
//
// Multicycle MIPS subset core: START -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
// with an absorbing HALT state for illegal instructions. One memory port is shared
// between instruction fetch and lw/sw data transfers.
//
// Supported: add, sub, and, or, slt, addi, lw, sw, beq, j.
// Optional:  jal / jr, enabled by defining MIPS_LITE_MC_JAL_EN. When the macro is
//            undefined, opcode 03 and funct 08 are illegal and halt the core.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   AW        width of mem_addr (8..32)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   mem_req    transfer request, held until mem_ready
//   mem_we     1 = write, 0 = read (valid with mem_req)
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_rdata  read data, sampled in the accepting cycle
//   mem_ready  completes the transfer on a rising edge with mem_req=1
//   pc_o       current PC
//   halted     core stopped on an illegal instruction
module mips_lite_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready,
    output logic [31:0]   pc_o,
    output logic          halted
);

`ifdef MIPS_LITE_MC_JAL_EN
    localparam logic JAL_EN = 1'b1;
`else
    localparam logic JAL_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;       // rs operand latched in DECODE
    logic [31:0] b_q, b_d;       // rt operand latched in DECODE
    logic [31:0] tgt_q, tgt_d;   // branch target latched in DECODE
    logic [31:0] alu_q, alu_d;   // ALU result / data address / link address
    logic [31:0] mdr_q, mdr_d;   // load data captured on acceptance
    logic [31:0] regs_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, jtarget, rs_val, rt_val;
    logic        unused_shamt;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign simm    = {{16{ir_q[15]}}, ir_q[15:0]};
    // Evaluated in EXEC, where pc_q already holds pc+4.
    assign jtarget = {pc_q[31:28], ir_q[25:0], 2'b00};
    assign rs_val  = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rt_val  = (rt == 5'd0) ? 32'd0 : regs_q[rt];
    assign unused_shamt = ^ir_q[10:6];

    assign pc_o = pc_q;

    function automatic logic [31:0] alu_r(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        case (fn)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
                    F_JR:                             return JAL_EN;
                    default:                          return 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            OP_JAL:                              return JAL_EN;
            default:                             return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        tgt_d     = tgt_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        halted    = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {pc_q[AW-1:2], 2'b00};
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                pc_d  = pc_q + 32'd4;
                tgt_d = pc_q + 32'd4 + {simm[29:0], 2'b00};
                state_d = instr_legal(opcode, funct) ? S_EXEC : S_HALT;
            end

            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == F_JR) begin
                            pc_d    = a_q;
                            state_d = S_FETCH;
                        end else begin
                            alu_d   = alu_r(funct, a_q, b_q);
                            state_d = S_WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + simm;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + simm;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = tgt_q;
                        end
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jtarget;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        // Link value is the already-incremented PC.
                        alu_d   = pc_q;
                        pc_d    = jtarget;
                        state_d = S_WB;
                    end
                    default: begin
                        state_d = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (opcode == OP_SW);
                mem_addr  = {alu_q[AW-1:2], 2'b00};
                mem_wdata = (opcode == OP_SW) ? b_q : 32'd0;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                rf_we = 1'b1;
                if (opcode == OP_RTYPE) begin
                    rf_waddr = rd;
                end else if (opcode == OP_JAL) begin
                    rf_waddr = 5'd31;
                end else begin
                    rf_waddr = rt;
                end
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            tgt_q <= 32'd0;
            alu_q <= 32'd0;
            mdr_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            tgt_q <= tgt_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
            // $0 is never written so it stays 0.
            if (rf_we && (rf_waddr != 5'd0)) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_lite_multicycle.sv
// Testbench for mips_lite_multicycle: an instruction-set level reference model
// (register array, PC, private memory copy) predicts every bus transaction, the
// per-instruction cycle count and halting; directed programs plus random programs.
module tb_mips_lite_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc_o;
    logic        halted;

    mips_lite_multicycle dut (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc_o     (pc_o),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    logic [31:0] dut_mem [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic tick();
        @(negedge clk);
        mem_ready = 1'b0;
        cyc++;
    endtask

    // Executes one instruction of the ISA on the model state.
    task automatic model_step(output bit halt, output bit has_mem, output bit we,
                              output logic [31:0] addr, output logic [31:0] wdata,
                              output int base);
        logic [31:0] ins, npc, rsv, rtv, simm, res;
        int wi;
        ins  = m_mem[m_pc[9:2]];
        rsv  = m_regs[ins[25:21]];
        rtv  = m_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        npc  = m_pc + 32'd4;
        halt = 0; has_mem = 0; we = 0; addr = 0; wdata = 0; base = 3; wi = 0; res = 0;
        case (ins[31:26])
            6'h00: begin
                base = 4;
                wi   = int'(ins[15:11]);
                case (ins[5:0])
                    6'h20: res = rsv + rtv;
                    6'h22: res = rsv - rtv;
                    6'h24: res = rsv & rtv;
                    6'h25: res = rsv | rtv;
                    6'h2A: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
`ifdef MIPS_LITE_MC_JAL_EN
                    6'h08: begin wi = 0; base = 3; npc = rsv; end
`endif
                    default: begin halt = 1; wi = 0; end
                endcase
            end
            6'h08: begin base = 4; wi = int'(ins[20:16]); res = rsv + simm; end
            6'h23: begin
                base = 5; has_mem = 1; addr = (rsv + simm) & 32'hFFFF_FFFC;
                res = m_mem[addr[9:2]]; wi = int'(ins[20:16]);
            end
            6'h2B: begin
                base = 4; has_mem = 1; we = 1; addr = (rsv + simm) & 32'hFFFF_FFFC;
                wdata = rtv; m_mem[addr[9:2]] = rtv;
            end
            6'h04: if (rsv == rtv) npc = npc + (simm << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
`ifdef MIPS_LITE_MC_JAL_EN
            6'h03: begin base = 4; wi = 31; res = npc; npc = {npc[31:28], ins[25:0], 2'b00}; end
`endif
            default: halt = 1;
        endcase
        if (wi != 0) m_regs[wi] = res;
        m_pc = npc;
    endtask

    // Serves one bus transfer with random wait states and checks its attributes
    // on every cycle the request is pending.
    task automatic xfer(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int wpct,
                        output bit ok, output int start, output int waits);
        bit seen;
        ok = 0; start = 0; waits = 0; seen = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (!mem_req) begin
                if (seen) begin
                    chk({tag, "_req_held"}, {31'd0, mem_req}, 32'd1);
                    return;
                end
                continue;
            end
            if (!seen) begin
                seen  = 1;
                start = cyc;
            end
            chk({tag, "_addr"}, mem_addr, addr);
            chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
            if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
            if ($urandom_range(0, 99) < wpct) begin
                waits++;
            end else begin
                mem_ready = 1'b1;
                if (we) dut_mem[mem_addr[9:2]] = mem_wdata;
                else    mem_rdata = dut_mem[mem_addr[9:2]];
                ok = 1;
                return;
            end
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_prog(input int max_n, input int wpct, input bit do_assert,
                            output bit halt_seen);
        bit h, hm, we, ok;
        logic [31:0] a, wd, pcb;
        int base, st, st2, w1, w2, prev_start, prev_exp, n;
        halt_seen = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = dut_mem[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
        if (do_assert) begin
            reset = 1'b1;
            #1;
            chk("rst_pc", pc_o, 32'd0);
            chk("rst_req", {31'd0, mem_req}, 32'd0);
            chk("rst_we", {31'd0, mem_we}, 32'd0);
            chk("rst_addr", mem_addr, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
            chk("rst_halted", {31'd0, halted}, 32'd0);
            tick();
        end
        tick();
        reset   = 1'b0;
        rel_cyc = cyc;
        chk("rel_req", {31'd0, mem_req}, 32'd0);
        prev_start = rel_cyc;
        prev_exp   = 1;
        for (int i = 0; i < max_n; i++) begin
            pcb = m_pc;
            model_step(h, hm, we, a, wd, base);
            xfer("fetch", 1'b0, pcb & 32'hFFFF_FFFC, 32'd0, wpct, ok, st, w1);
            if (!ok) return;
            chk((i == 0) ? "first_req" : "cycles", st - prev_start, prev_exp);
            chk("fetch_pc", pc_o, pcb);
            chk("run_halted", {31'd0, halted}, 32'd0);
            if (h) begin
                n = 0;
                while (!halted && n < 5) begin
                    tick();
                    n++;
                end
                chk("halt", {31'd0, halted}, 32'd1);
                chk("halt_pc", pc_o, m_pc);
                repeat (4) begin
                    tick();
                    chk("halt_req", {31'd0, mem_req}, 32'd0);
                    chk("halt_hold", {31'd0, halted}, 32'd1);
                end
                halt_seen = 1;
                return;
            end
            w2 = 0;
            if (hm) begin
                xfer(we ? "store" : "load", we, a, wd, wpct, ok, st2, w2);
                if (!ok) return;
            end
            prev_start = st;
            prev_exp   = base + w1 + w2;
        end
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 256; i++) dut_mem[i] = ILLEGAL;
        dut_mem[0]  = enc_i(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
        dut_mem[1]  = enc_i(6'h08, 0, 2, 16'd7);        // addi $2,$0,7
        dut_mem[2]  = enc_r(1, 2, 3, 6'h20);            // add  $3,$1,$2
        dut_mem[3]  = enc_i(6'h2B, 0, 3, 16'h0080);     // sw   $3,0x80($0)
        dut_mem[4]  = enc_i(6'h23, 0, 4, 16'h00C0);     // lw   $4,0xC0($0)
        dut_mem[5]  = enc_i(6'h2B, 0, 4, 16'h0084);     // sw   $4,0x84($0)
        dut_mem[6]  = enc_i(6'h08, 0, 0, 16'd9);        // addi $0,$0,9
        dut_mem[7]  = enc_i(6'h2B, 0, 0, 16'h0088);     // sw   $0,0x88($0)
        dut_mem[8]  = enc_i(6'h23, 0, 5, 16'h00C4);     // lw   $5,0xC4($0)
        dut_mem[9]  = enc_i(6'h2B, 0, 5, 16'h0013);     // sw   $5,0x13($0) -> 0x10
        dut_mem[10] = enc_i(6'h08, 0, 1, 16'd3);        // addi $1,$0,3
        dut_mem[11] = enc_i(6'h08, 0, 2, 16'd4);        // addi $2,$0,4
        dut_mem[12] = enc_i(6'h04, 1, 2, 16'd2);        // beq  not taken
        dut_mem[13] = enc_i(6'h08, 0, 2, 16'd3);        // addi $2,$0,3
        dut_mem[14] = enc_i(6'h04, 1, 2, 16'd2);        // beq  taken -> 0x44
        dut_mem[17] = enc_j(6'h03, 26'h18);             // jal  0x60
        dut_mem[24] = enc_i(6'h2B, 0, 31, 16'h008C);    // sw   $31,0x8C($0)
        dut_mem[25] = enc_r(31, 0, 0, 6'h08);           // jr   $31 -> 0x48
        dut_mem[48] = 32'hDEAD_BEEF;
        dut_mem[49] = 32'h1234_5678;
    endtask

    task automatic check_prog_a();
        chk("add_result", dut_mem[32], 32'd12);
        chk("lw_result", dut_mem[33], 32'hDEAD_BEEF);
        chk("r0_zero", dut_mem[34], 32'd0);
        chk("sw_aligned", dut_mem[4], 32'h1234_5678);
`ifdef MIPS_LITE_MC_JAL_EN
        chk("jal_link", dut_mem[35], 32'h0000_0048);
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        logic [5:0] fn;
        logic [15:0] imm;
        k  = $urandom_range(0, 99);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        imm = 16'(32'h0200 + $urandom_range(0, 511));
        if (k < 32) return enc_r(rs, rt, rd, fn);
        if (k < 52) return enc_i(6'h08, rs, rt, 16'($urandom));
        if (k < 64) return enc_i(6'h23, $urandom_range(0, 1) ? 0 : rs, rt, imm);
        if (k < 76) return enc_i(6'h2B, $urandom_range(0, 1) ? 0 : rs, rt, imm);
        if (k < 88) return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 6)) - 16'd3);
        if (k < 93) return enc_j(6'h02, 26'($urandom_range(0, 127)));
        if (k < 96) return enc_j(6'h03, 26'($urandom_range(0, 127)));
        if (k < 98) return enc_r(rs, 0, 0, 6'h08);
        return enc_i(6'h3F, rs, rt, 16'($urandom));
    endfunction

    initial begin
        bit hs;
        int n;

        // Directed program, zero-wait then with wait states.
        load_prog_a();
        run_prog(60, 0, 1'b1, hs);
        chk("progA_halts", {31'd0, hs}, 32'd1);
        check_prog_a();
        load_prog_a();
        run_prog(60, 40, 1'b1, hs);
        chk("progA_wait_halts", {31'd0, hs}, 32'd1);
        check_prog_a();

        // Reset during a stalled fetch, then confirm registers were cleared.
        load_prog_a();
        run_prog(5, 0, 1'b1, hs);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req && n < 10);
        chk("stall_req", {31'd0, mem_req}, 32'd1);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("stall_rst_pc", pc_o, 32'd0);
        chk("stall_rst_req", {31'd0, mem_req}, 32'd0);
        chk("stall_rst_addr", mem_addr, 32'd0);
        tick();
        chk("stall_rst_req_next", {31'd0, mem_req}, 32'd0);
        dut_mem[0] = enc_i(6'h2B, 0, 3, 16'h0090);
        dut_mem[1] = enc_i(6'h2B, 0, 4, 16'h0094);
        dut_mem[2] = ILLEGAL;
        run_prog(10, 0, 1'b0, hs);
        chk("regs_cleared_3", dut_mem[36], 32'd0);
        chk("regs_cleared_4", dut_mem[37], 32'd0);

        // Random programs.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 128; w++) dut_mem[w] = rand_instr();
            for (int w = 128; w < 256; w++) dut_mem[w] = $urandom;
            run_prog(150, (r % 2 == 1) ? 30 : 0, 1'b1, hs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_lite_multicycle.md
MIPS_LITE_MULTICYCLE -- requirements
Module: mips_lite_multicycle

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter AW, default 32, range 8..32, giving the width of mem_addr.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_req  output  1  memory transfer request, held until accepted.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  AW  word-aligned byte address (bits [1:0] always 00).
REQ-008 mem_wdata  output  32  store data, big-endian word.
REQ-009 mem_rdata  input  32  read data; valid in the accepting cycle.
REQ-010 mem_ready  input  1  a transfer completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-011 pc_o  output  32  current PC.
REQ-012 halted  output  1  core is stopped on an illegal instruction.

Function
REQ-013 The block SHALL implement a multicycle FSM with states START, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 START SHALL drive mem_req=0 and go to FETCH after one cycle.
REQ-015 FETCH SHALL read the word at pc, latch it into IR on acceptance, then go to DECODE; it SHALL stay in FETCH while mem_ready=0.
REQ-016 DECODE SHALL read rs/rt, set pc<=pc+4, compute branch target pc+4+(sext(imm)<<2), and go to EXEC; an illegal opcode or funct SHALL go to HALT with pc left at pc+4.
REQ-017 Supported instructions: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), addi (08), lw (23), sw (2B), beq (04), j (02).
REQ-018 Arithmetic SHALL be 32-bit modulo 2^32 with overflow ignored; slt SHALL compare signed; immediates SHALL be sign-extended.
REQ-019 EXEC routing: R-type and addi go to WB; lw and sw go to MEM; beq updates pc to target when rs==rt, then goes to FETCH; j sets pc={pc[31:28],imm26,2'b00}, then goes to FETCH.
REQ-020 MEM SHALL issue the transfer at rs+sext(imm) with bits [1:0] forced to 00, truncated to AW bits, and wait for mem_ready.
REQ-021 After MEM, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-022 WB SHALL write rd (R-type) or rt (addi, lw), then go to FETCH.
REQ-023 Writes to $0 SHALL be discarded, and $0 SHALL always read 0.
REQ-024 With zero-wait memory the cycle counts SHALL be: R-type and addi 4, lw 5, sw 4, beq and j 3; each wait cycle adds 1.
REQ-025 mem_req SHALL be 1 only in FETCH and in MEM for lw/sw.
REQ-026 mem_addr, mem_we and mem_wdata SHALL be stable while mem_req=1 and mem_ready=0.
REQ-027 HALT SHALL be absorbing: halted=1 and mem_req=0 until reset.

Reset
REQ-028 Asserting reset SHALL immediately force state=START, pc=RESET_PC, IR=0, all 32 registers to 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 and halted=0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no register or PC update.
REQ-030 The first mem_req after reset release SHALL occur in the second rising edge's cycle, because START is visited first.

Configuration
REQ-031 The macro MIPS_LITE_MC_JAL_EN SHALL control jal support.
REQ-032 With MIPS_LITE_MC_JAL_EN defined, jal (opcode 03) SHALL write the return address pc+4 to $31 and jump as j, in 4 cycles (DECODE→EXEC→WB).
REQ-033 With MIPS_LITE_MC_JAL_EN defined, jr (R-type funct 08) SHALL set pc=rs in 3 cycles.
REQ-034 Without MIPS_LITE_MC_JAL_EN, opcode 03 and funct 08 SHALL be illegal and go to HALT.

Verification
REQ-035 $1=5, $2=7, zero-wait memory, "add $3,$1,$2" at 0 -> $3=12 after 4 cycles and pc_o=4.
REQ-036 Memory word 0x40=0xDEADBEEF, "lw $4,0x40($0)" with mem_ready low for 2 cycles in MEM -> $4=0xDEADBEEF after 7 cycles and mem_addr stable during the wait.
REQ-037 $1=$2=3, "beq $1,$2,+2" at 0x8 -> pc_o=0x14 after 3 cycles; with $2=4 -> pc_o=0xC.
REQ-038 "sw $5,0x13($0)" with $5=0x12345678 -> a single write at mem_addr=0x10 with mem_wdata=0x12345678 and mem_we=1; "addi $0,$0,9" -> $0 reads 0.
REQ-039 Opcode 3F -> halted=1 and mem_req=0 forever; reset asserted during a stalled FETCH -> pc_o=RESET_PC immediately and mem_req=0 in the next cycle.
REQ-040 With MIPS_LITE_MC_JAL_EN, "jal 0x40" at 0x8 -> $31=0xC and pc_o=0x100; without the macro, the same instruction -> halted=1.
